// File: rtl/dds_wave_lut.sv
// dds_wave_lut: phase-to-amplitude stage after the DDS accumulator.
// Sine uses a quarter-wave ROM; square, triangle and sawtooth are computed.
// Optional build macro DDS_SYNC_SWITCH_EN: wave_sel changes wait for the
// next phase wrap (glitch-free); otherwise they apply on the next sample.
// Ports: clk, rst_n (async active-low), acc_in/acc_vld (accumulator in),
//   P (phase offset), wave_sel (0 sin,1 sqr,2 tri,3 saw),
//   wave_out/wave_vld (sample out, 3-cycle latency), sel_busy (switch pending).
`timescale 1ns/1ps
module dds_wave_lut #(
  parameter int ACC_W = 32,
  parameter int PH_W  = 11,
  parameter int AMP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             acc_vld,
  input  logic [PH_W-1:0]  P,
  input  logic [1:0]       wave_sel,
  output logic [AMP_W-1:0] wave_out,
  output logic             wave_vld,
  output logic             sel_busy
);

  localparam int A_W   = PH_W - 2;
  localparam int DEPTH = 1 << A_W;

  // Fixed-point (Q30) Taylor series, evaluated at elaboration only.
  function automatic logic [A_W-1:0] sin_q(input int i);
    longint x, term, sum, v;
    x    = (64'sd3373259426 * longint'(2 * i + 1)) / 64'sd2048;
    term = x;
    sum  = x;
    for (int k = 1; k < 9; k++) begin
      term = -((((term * x) >>> 30) * x) >>> 30)
             / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    v = (sum * 64'sd511 + 64'sd536870912) >>> 30;
    return A_W'(v);
  endfunction

  logic [A_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [A_W-1:0] V = sin_q(g);
    assign rom[g] = V;
  end

  // Stage 1: phase, wrap detect, selection
  logic [PH_W-1:0] ph;
  logic            wrap;
  logic            prev_msb;
  logic [1:0]      sel_nxt;
  logic            unused_acc;

  assign ph   = acc_in[ACC_W-1 -: PH_W] + P;
  assign wrap = acc_vld & prev_msb & ~ph[PH_W-1];
  assign unused_acc = ^acc_in[ACC_W-PH_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_msb <= 1'b0;
    end else if (acc_vld) begin
      prev_msb <= ph[PH_W-1];
    end
  end

`ifdef DDS_SYNC_SWITCH_EN
  typedef enum logic {ACTIVE, PENDING} state_t;

  state_t     state, state_nxt;
  logic [1:0] active_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACTIVE;
      active_sel <= 2'd0;
    end else begin
      state      <= state_nxt;
      active_sel <= sel_nxt;
    end
  end

  // A change seen in ACTIVE only arms the request, even on a wrap
  // sample; the switch lands on the next wrap with the newest select.
  always_comb begin
    state_nxt = state;
    sel_nxt   = active_sel;
    unique case (state)
      ACTIVE: begin
        if (wave_sel != active_sel) state_nxt = PENDING;
      end
      PENDING: begin
        if (wave_sel == active_sel) begin
          state_nxt = ACTIVE;
        end else if (wrap) begin
          sel_nxt   = wave_sel;
          state_nxt = ACTIVE;
        end
      end
    endcase
  end

  assign sel_busy = (state == PENDING);
`else
  assign sel_nxt  = wave_sel;
  assign sel_busy = 1'b0;
`endif

  logic            vld1;
  logic [PH_W-1:0] ph1;
  logic [1:0]      sel1;

  // Each sample carries the selection in force for it, so a switch
  // can never split a sample across the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1 <= 1'b0;
      ph1  <= '0;
      sel1 <= 2'd0;
    end else begin
      vld1 <= acc_vld;
      ph1  <= ph;
      sel1 <= sel_nxt;
    end
  end

  // Stage 2: mirrored address in odd quadrants, ROM read
  logic [A_W-1:0]  addr;
  logic            vld2;
  logic [PH_W-1:0] ph2;
  logic [1:0]      sel2;
  logic [A_W-1:0]  rom_q;

  assign addr = ph1[A_W-1:0] ^ {A_W{ph1[PH_W-2]}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld2  <= 1'b0;
      ph2   <= '0;
      sel2  <= 2'd0;
      rom_q <= '0;
    end else begin
      vld2  <= vld1;
      ph2   <= ph1;
      sel2  <= sel1;
      rom_q <= rom[addr];
    end
  end

  // Stage 3: shape select; 512+lut / 511-lut and 1023-x are bit tricks
  logic [AMP_W-1:0] amp;

  always_comb begin
    amp = '0;
    unique case (sel2)
      2'd0: amp = ph2[PH_W-1] ? {1'b0, ~rom_q} : {1'b1, rom_q};
      2'd1: amp = ph2[PH_W-1] ? '0 : '1;
      2'd2: amp = ph2[PH_W-1] ? ~ph2[AMP_W-1:0] : ph2[AMP_W-1:0];
      2'd3: amp = ph2[PH_W-1:1];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_out <= '0;
      wave_vld <= 1'b0;
    end else begin
      wave_vld <= vld2;
      if (vld2) wave_out <= amp;
    end
  end

endmodule

// File: tb/tb_dds_wave_lut.sv
// tb_dds_wave_lut: scoreboard bench for dds_wave_lut.
// Expected samples are queued at drive time and matched on wave_vld.
`timescale 1ns/1ps
module tb_dds_wave_lut;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] acc_in = '0;
  logic        acc_vld = 1'b0;
  logic [10:0] P = '0;
  logic [1:0]  wave_sel = '0;
  logic [9:0]  wave_out;
  logic        wave_vld;
  logic        sel_busy;

  dds_wave_lut dut (
    .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .acc_vld(acc_vld),
    .P(P), .wave_sel(wave_sel), .wave_out(wave_out),
    .wave_vld(wave_vld), .sel_busy(sel_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  val;
  } smp_t;

  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  logic [8:0] lut [512];
  logic [1:0] cur_sel = 2'd0;
  smp_t       exp_q[$];
  smp_t       obs_q[$];
  smp_t       e, o;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wave_vld) obs_q.push_back('{32'(cyc), wave_out});
  end

  function automatic logic [9:0] model(logic [10:0] ph, logic [1:0] s);
    logic [8:0] a;
    logic [8:0] l;
    case (s)
      2'd0: begin
        a = ph[9] ? 9'(511 - int'(ph[8:0])) : ph[8:0];
        l = lut[a];
        return ph[10] ? 10'(511 - int'(l)) : 10'(512 + int'(l));
      end
      2'd1: return ph[10] ? 10'd0 : 10'd1023;
      2'd2: return ph[10] ? 10'(1023 - int'(ph[9:0])) : ph[9:0];
      default: return ph[10:1];
    endcase
  endfunction

  function automatic logic [10:0] phase(logic [31:0] a, logic [10:0] p);
    return a[31:21] + p;
  endfunction

  task automatic step(input logic v, input logic [31:0] a,
                      input logic [10:0] p, input logic [1:0] s,
                      input logic [9:0] ev);
    @(negedge clk);
    acc_vld  = v;
    acc_in   = a;
    P        = p;
    wave_sel = s;
    if (v) exp_q.push_back('{32'(cyc + 3), ev});
    @(posedge clk);
  endtask

  task automatic flush();
    @(negedge clk);
    acc_vld = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  // Works in both builds: a wrap sample follows the request.
  task automatic set_sel(input logic [1:0] s);
    step(1, 32'hFFE00000, 0, cur_sel, model(11'd2047, cur_sel));
    step(0, 0, 0, s, 0);
    step(1, 32'h00000000, 0, s, model(11'd0, s));
    cur_sel = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wave_out !== 10'd0)
      $display("FAIL reset wave_out: got %0d, expected 0", wave_out);
    else passed++;
    checks++;
    if (wave_vld !== 1'b0)
      $display("FAIL reset wave_vld: got %b, expected 0", wave_vld);
    else passed++;
    checks++;
    if (sel_busy !== 1'b0)
      $display("FAIL reset sel_busy: got %b, expected 0", sel_busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sine();
    logic [31:0] a;
    logic [10:0] p;
    step(1, 32'h00000000, 0, 0, 10'd513);
    step(1, 32'h40000000, 0, 0, 10'd1023);
    step(1, 32'hC0000000, 0, 0, 10'd0);
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      p = 11'($urandom_range(0, 2047));
      step(1, a, p, 0, model(phase(a, p), 0));
    end
    flush();
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL sine count: got %0d, expected %0d",
               obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL sine: got cyc %0d val %0d, expected cyc %0d val %0d",
                 o.cyc, o.val, e.cyc, e.val);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_offset();
    step(1, 32'hFFE00000, 11'd1, 0, 10'd513);
    step(1, 32'hFFE00000, 11'd512, 0, 10'd1023);
    flush();
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL offset count: got %0d, expected %0d",
               obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL offset: got cyc %0d val %0d, expected cyc %0d val %0d",
                 o.cyc, o.val, e.cyc, e.val);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_shapes();
    logic [9:0]  ex [4] = '{10'd0, 10'd0, 10'd1023, 10'd512};
    logic [9:0]  e0 [4] = '{10'd513, 10'd1023, 10'd0, 10'd0};
    logic [31:0] a;
    for (int s = 1; s < 4; s++) begin
      set_sel(2'(s));
      step(1, 32'h00000000, 0, 2'(s), e0[s]);
      step(1, 32'h80000000, 0, 2'(s), ex[s]);
      for (int i = 0; i < 2; i++) begin
        a = $urandom();
        step(1, a, 0, 2'(s), model(phase(a, 0), 2'(s)));
      end
    end
    set_sel(2'd0);
    flush();
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL shapes count: got %0d, expected %0d",
               obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL shapes: got cyc %0d val %0d, expected cyc %0d val %0d",
                 o.cyc, o.val, e.cyc, e.val);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_bubbles();
    logic [7:0]  pat = 8'b1001_1101;
    logic [31:0] a;
    logic [10:0] p;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      p = 11'($urandom_range(0, 2047));
      step(pat[i], a, p, 0, model(phase(a, p), 0));
    end
    flush();
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL bubbles count: got %0d, expected %0d",
               obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL bubbles: got cyc %0d val %0d, expected cyc %0d val %0d",
                 o.cyc, o.val, e.cyc, e.val);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_switch();
    int         ph;
    logic       wrapped;
    logic [1:0] s, es;
    logic       busy_any;
    wrapped  = 1'b0;
    busy_any = 1'b0;
    ph       = 1500;
    for (int i = 0; i < 8; i++) begin
      s = (ph >= 1600 || wrapped) ? 2'd1 : 2'd0;
      if (i == 6) wrapped = 1'b1;
`ifdef DDS_SYNC_SWITCH_EN
      es = wrapped ? 2'd1 : 2'd0;
`else
      es = s;
`endif
      step(1, {11'(ph), 21'd0}, 0, s, model(11'(ph), es));
      #1;
      busy_any = busy_any | sel_busy;
`ifdef DDS_SYNC_SWITCH_EN
      if (i == 1) begin
        checks++;
        if (sel_busy !== 1'b1)
          $display("FAIL switch busy set: got %b, expected 1", sel_busy);
        else passed++;
      end
      if (i == 6) begin
        checks++;
        if (sel_busy !== 1'b0)
          $display("FAIL switch busy clr: got %b, expected 0", sel_busy);
        else passed++;
      end
`endif
      ph = (ph + 100) % 2048;
    end
    cur_sel = 2'd1;
`ifndef DDS_SYNC_SWITCH_EN
    checks++;
    if (busy_any !== 1'b0)
      $display("FAIL switch busy: got %b, expected 0", busy_any);
    else passed++;
`endif
    flush();
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL switch count: got %0d, expected %0d",
               obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL switch: got cyc %0d val %0d, expected cyc %0d val %0d",
                 o.cyc, o.val, e.cyc, e.val);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 3; i++)
      step(1, {11'd100, 21'd0}, 0, cur_sel, 10'd1023);
    #2;
    checks++;
    if (wave_vld !== 1'b1 || wave_out !== 10'd1023)
      $display("FAIL pre-reset out: got vld %b val %0d, expected 1 1023",
               wave_vld, wave_out);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wave_vld !== 1'b0)
      $display("FAIL midreset wave_vld: got %b, expected 0", wave_vld);
    else passed++;
    checks++;
    if (wave_out !== 10'd0)
      $display("FAIL midreset wave_out: got %0d, expected 0", wave_out);
    else passed++;
    acc_vld = 1'b0;
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    rst_n   = 1'b1;
    cur_sel = 2'd0;
    repeat (2) @(posedge clk);
    step(1, 32'h00000000, 0, 0, 10'd513);
    flush();
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL midreset count: got %0d, expected %0d",
               obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL midreset: got cyc %0d val %0d, expected cyc %0d val %0d",
                 o.cyc, o.val, e.cyc, e.val);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

`ifdef DDS_SYNC_SWITCH_EN
  task automatic test_cancel();
    int         ph;
    logic [1:0] s;
    ph = 1500;
    for (int i = 0; i < 8; i++) begin
      s = (i == 1 || i == 2) ? 2'd1 : 2'd0;
      step(1, {11'(ph), 21'd0}, 0, s, model(11'(ph), 2'd0));
      #1;
      if (i == 1) begin
        checks++;
        if (sel_busy !== 1'b1)
          $display("FAIL cancel busy set: got %b, expected 1", sel_busy);
        else passed++;
      end
      if (i == 3) begin
        checks++;
        if (sel_busy !== 1'b0)
          $display("FAIL cancel busy clr: got %b, expected 0", sel_busy);
        else passed++;
      end
      ph = (ph + 100) % 2048;
    end
    flush();
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL cancel count: got %0d, expected %0d",
               obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL cancel: got cyc %0d val %0d, expected cyc %0d val %0d",
                 o.cyc, o.val, e.cyc, e.val);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  initial begin
    for (int i = 0; i < 512; i++)
      lut[i] = 9'(int'(511.0 * $sin(3.14159265358979 * (2 * i + 1) / 2048.0)));
    test_reset();
    test_sine();
    test_offset();
    test_shapes();
    test_bubbles();
    test_switch();
    test_midreset();
`ifdef DDS_SYNC_SWITCH_EN
    test_cancel();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
